half_adder_pipe: RTL and testbench

- Bank of WIDTH independent 1-bit half adders: sum = a XOR b, carry = a AND b, per lane.
- Optional output register stage, with a valid flag travelling alongside the data.
- Used as a leaf arithmetic primitive; a default configuration of WIDTH=1, REG_OUT=1 gives a registered single half adder.

---
 rtl/half_adder_pipe_if.sv | 22 ++
 rtl/half_adder_pipe.sv | 47 ++++
 tb/tb_half_adder_pipe.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/half_adder_pipe_if.sv
// Operand/result bundle for half_adder_pipe. in_valid qualifies a/b for one cycle;
// out_valid qualifies sum/carry. There is no ready: the consumer always accepts.
interface half_adder_pipe_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;
  logic             out_valid;

  modport master (
    output in_valid, a, b,
    input  sum, carry, out_valid
  );

  modport slave (
    input  in_valid, a, b,
    output sum, carry, out_valid
  );
endinterface

// File: rtl/half_adder_pipe.sv
// Bank of WIDTH independent half adders with an optional output register stage.
// A lane's {carry,sum} is the 2-bit sum of its a and b bits. Lanes do not interact.
module half_adder_pipe #(
  parameter int WIDTH   = 1,
  parameter int REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  half_adder_pipe_if.slave bus
);

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] carry_d;

  assign sum_d   = bus.a ^ bus.b;
  assign carry_d = bus.a & bus.b;

  if (REG_OUT != 0) begin : g_reg
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] carry_q;
    logic             out_valid_q;

    // Data loads only on in_valid, so X operands in idle cycles never reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q       <= '0;
        carry_q     <= '0;
        out_valid_q <= 1'b0;
      end else begin
        out_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          sum_q   <= sum_d;
          carry_q <= carry_d;
        end
      end
    end

    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;
    assign bus.out_valid = out_valid_q;
  end else begin : g_comb
    assign bus.sum       = sum_d;
    assign bus.carry     = carry_d;
    assign bus.out_valid = bus.in_valid;
  end

endmodule

// File: tb/tb_half_adder_pipe.sv
// Bench for half_adder_pipe: registered WIDTH=1 and WIDTH=4 instances plus a
// combinational WIDTH=1 instance, checked against expected queues and vector tables.
module tb_half_adder_pipe;

  typedef struct {
    logic v;
    logic a;
    logic b;
    logic exp_v;
    logic exp_c;
    logic exp_s;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [8:0] exp1_q[$];
  logic [8:0] exp4_q[$];
  logic [3:0] hold4_c = 4'h0;
  logic [3:0] hold4_s = 4'h0;
  vec_t       vecs[10];

  always #5 clk = ~clk;

  half_adder_pipe_if #(.WIDTH(1)) bus1 ();
  half_adder_pipe_if #(.WIDTH(4)) bus4 ();
  half_adder_pipe_if #(.WIDTH(1)) busc ();

  half_adder_pipe #(.WIDTH(1), .REG_OUT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  half_adder_pipe #(.WIDTH(4), .REG_OUT(1)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  half_adder_pipe #(.WIDTH(1), .REG_OUT(0)) dutc (.clk(clk), .rst_n(rst_n), .bus(busc));

  function automatic logic [8:0] pack(input logic v, input logic [3:0] c, input logic [3:0] s);
    return {v, c, s};
  endfunction

  function automatic logic [8:0] obs1();
    return pack(bus1.out_valid, {3'b000, bus1.carry}, {3'b000, bus1.sum});
  endfunction

  function automatic logic [8:0] obs4();
    return pack(bus4.out_valid, bus4.carry, bus4.sum);
  endfunction

  function automatic logic [8:0] obsc();
    return pack(busc.out_valid, {3'b000, busc.carry}, {3'b000, busc.sum});
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual{v,c,s}=%b required{v,c,s}=%b", name, act, req);
    end
  endtask

  task automatic pop_check1(input string name);
    logic [8:0] e;
    if (exp1_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s actual=no_expected_entry required=queued_entry", name);
    end else begin
      e = exp1_q.pop_front();
      check(name, obs1(), e);
    end
  endtask

  task automatic pop_check4(input string name);
    logic [8:0] e;
    if (exp4_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s actual=no_expected_entry required=queued_entry", name);
    end else begin
      e = exp4_q.pop_front();
      check(name, obs4(), e);
    end
  endtask

  // Lane result modelled as 2-bit addition; idle cycles keep the last captured result.
  task automatic drive4(input logic v, input logic [3:0] a, input logic [3:0] b);
    logic [1:0] t;
    bus4.in_valid = v;
    bus4.a        = a;
    bus4.b        = b;
    if (v) begin
      for (int i = 0; i < 4; i++) begin
        t = {1'b0, a[i]} + {1'b0, b[i]};
        hold4_c[i] = t[1];
        hold4_s[i] = t[0];
      end
    end
    exp4_q.push_back(pack(v, hold4_c, hold4_s));
  endtask

  initial begin
    logic [1:0] t;

    // {v,a,b} -> expected {out_valid,carry,sum} one edge later
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'bx, 1'bx, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    busc.in_valid = 1'b0;
    busc.a        = 1'b0;
    busc.b        = 1'b0;

    // Reset held with live, valid operands and a running clock
    bus1.in_valid = 1'b1;
    bus1.a        = 1'b1;
    bus1.b        = 1'b1;
    bus4.in_valid = 1'b1;
    bus4.a        = 4'hF;
    bus4.b        = 4'hF;
    repeat (3) begin
      @(negedge clk);
      check("reset_hold_w1", obs1(), 9'h000);
      check("reset_hold_w4", obs4(), 9'h000);
    end

    rst_n         = 1'b1;
    bus4.in_valid = 1'b0;
    exp1_q.push_back(pack(1'b1, 4'h1, 4'h0));

    foreach (vecs[i]) begin
      @(negedge clk);
      pop_check1($sformatf("w1_step%0d", i));
      bus1.in_valid = vecs[i].v;
      bus1.a        = vecs[i].a;
      bus1.b        = vecs[i].b;
      exp1_q.push_back(pack(vecs[i].exp_v, {3'b000, vecs[i].exp_c}, {3'b000, vecs[i].exp_s}));
    end
    @(negedge clk);
    pop_check1("w1_step_last");
    bus1.in_valid = 1'b0;

    // Multi-lane: directed pattern, random mix of valid/idle, then all-ones
    drive4(1'b1, 4'b1100, 4'b1010);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      pop_check4($sformatf("w4_step%0d", k));
      drive4(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    @(negedge clk);
    pop_check4("w4_step_last");
    drive4(1'b1, 4'hF, 4'hF);
    bus1.in_valid = 1'b1;
    bus1.a        = 1'b1;
    bus1.b        = 1'b1;

    // Async reset between edges must clear outputs before the next posedge
    @(negedge clk);
    pop_check4("w4_pre_rst");
    check("w1_pre_rst", obs1(), pack(1'b1, 4'h1, 4'h0));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clr_w1", obs1(), 9'h000);
    check("async_clr_w4", obs4(), 9'h000);
    exp4_q.delete();
    hold4_c = 4'h0;
    hold4_s = 4'h0;
    @(negedge clk);
    check("rst_ignore_w1", obs1(), 9'h000);
    check("rst_ignore_w4", obs4(), 9'h000);

    rst_n         = 1'b1;
    bus1.in_valid = 1'b0;
    drive4(1'b1, 4'b0011, 4'b0101);
    @(negedge clk);
    pop_check4("w4_after_rst");
    check("w1_idle_after_rst", obs1(), 9'h000);
    bus4.in_valid = 1'b0;

    // Combinational instance: zero latency, out_valid follows in_valid
    busc.in_valid = 1'b1;
    busc.a        = 1'b1;
    busc.b        = 1'b1;
    #1;
    check("comb_11", obsc(), pack(1'b1, 4'h1, 4'h0));
    busc.in_valid = 1'b0;
    busc.a        = 1'b0;
    busc.b        = 1'b1;
    #1;
    check("comb_01", obsc(), pack(1'b0, 4'h0, 4'h1));
    for (int k = 0; k < 8; k++) begin
      busc.in_valid = k[2];
      busc.a        = k[1];
      busc.b        = k[0];
      #1;
      t = {1'b0, k[1]} + {1'b0, k[0]};
      check($sformatf("comb_table%0d", k), obsc(), pack(k[2], {3'b000, t[1]}, {3'b000, t[0]}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
